// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch buffer.
// Optional same-cycle response bypass is enabled by defining IFETCH_BYPASS_EN.
package ifetch_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefDepth     = 4;

  typedef enum logic [0:0] {
    StRun,
    StDiscard
  } state_e;

  // Counts must hold the value DEPTH itself, hence one bit more than a pointer.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; flush wins over a same-cycle push or pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Credit accounting upstream makes this unreachable; firing means a broken invariant.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !flush_i))
    else $error("sync_fifo: push to full FIFO");

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues in-order reads at pc_in, pairs responses with their PC and
// queues them for decode. Define IFETCH_BYPASS_EN for same-cycle rvalid->inst_valid.
module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DefDataWidth,
  parameter int unsigned DEPTH     = DefDepth
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] pc_in,
  output logic                 pc_en,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [DATAWIDTH-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [DATAWIDTH-1:0] inst_data,
  output logic [DATAWIDTH-1:0] inst_pc
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  state_e               state_q, state_d;
  logic [CntW-1:0]      discard_q, discard_d;
  logic [CntW-1:0]      pend_count, out_count, outstanding;
  logic [CntW:0]        occupancy;
  logic [DATAWIDTH-1:0] pend_rdata;
  logic [2*DATAWIDTH-1:0] out_rdata;
  logic                 pend_full, pend_empty, out_full, out_empty;
  logic                 run, rsp, out_push, out_pop, byp_valid, byp_take;
  logic                 unused_flags;

  assign run = (state_q == StRun);

  // In RUN every in-flight request has a pending PC; in DISCARD the PCs are gone.
  assign outstanding = run ? pend_count : discard_q;
  assign occupancy   = {1'b0, out_count} + {1'b0, outstanding};

  assign mem_req  = clr & run & (occupancy < (CntW + 1)'(DEPTH)) & ~flush;
  assign pc_en    = mem_req & mem_gnt;
  assign mem_addr = pc_in;

  assign rsp = mem_rvalid & run & ~flush;

`ifdef IFETCH_BYPASS_EN
  assign byp_valid = rsp & out_empty;
`else
  assign byp_valid = 1'b0;
`endif
  assign byp_take = byp_valid & inst_ready;

  assign inst_valid = ~out_empty | byp_valid;
  assign inst_data  = byp_valid ? mem_rdata : out_rdata[DATAWIDTH-1:0];
  assign inst_pc    = byp_valid ? pend_rdata : out_rdata[2*DATAWIDTH-1:DATAWIDTH];
  assign out_push   = rsp & ~byp_take;
  assign out_pop    = ~out_empty & inst_ready;

  assign unused_flags = ^{pend_full, pend_empty, out_full};

  sync_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (DEPTH)
  ) u_pend_fifo (
    .clk_i   (clk),
    .rst_ni  (clr),
    .push_i  (pc_en),
    .wdata_i (pc_in),
    .pop_i   (rsp),
    .flush_i (flush),
    .rdata_o (pend_rdata),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .count_o (pend_count)
  );

  sync_fifo #(
    .WIDTH (2 * DATAWIDTH),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk_i   (clk),
    .rst_ni  (clr),
    .push_i  (out_push),
    .wdata_i ({pend_rdata, mem_rdata}),
    .pop_i   (out_pop),
    .flush_i (flush),
    .rdata_o (out_rdata),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    if (flush) begin
      // A response landing in the flush cycle is already accounted for by dropping it.
      discard_d = (mem_rvalid && (outstanding != '0)) ? outstanding - 1'b1 : outstanding;
      state_d   = (discard_d != '0) ? StDiscard : StRun;
    end else if (!run && mem_rvalid) begin
      discard_d = discard_q - 1'b1;
      if (discard_d == '0) state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StRun;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: directed vector table, corner sequences, then random traffic
// checked against a queue-based model of granted-but-not-consumed fetches.
module tb_ifetch_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [DW-1:0] pc_in = '0;
  logic          pc_en;
  logic          flush = 1'b0;
  logic          mem_req;
  logic [DW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [DW-1:0] inst_data;
  logic [DW-1:0] inst_pc;

  ifetch_buffer #(
    .DATAWIDTH (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .pc_in      (pc_in),
    .pc_en      (pc_en),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc;
    int unsigned   wait_cyc;
    bit            live;
  } mem_txn_t;

  typedef struct {
    logic [DW-1:0] pc;
    bit            arrived;
  } exp_t;

  typedef struct {
    logic gnt;
    logic ready;
    logic exp_req;
    logic exp_valid;
  } vec_t;

  mem_txn_t      inflight[$];
  exp_t          exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int unsigned   next_wait = 0;
  bit            rand_wait = 1'b0;
  logic [DW-1:0] flush_pc = '0;
  bit            want_first = 1'b0;
  logic [DW-1:0] first_pc = '0;
  logic          s_req, s_pcen, s_valid;

  function automatic logic [DW-1:0] word_of(input logic [DW-1:0] pc);
    return {pc[15:0] ^ 16'hbeef, pc[31:16]} + 32'h1357;
  endfunction

  task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One clock cycle: drive memory, check at negedge, update models, step the counter.
  task automatic step();
    bit            rv, head_live, byp, exp_req, exp_valid, consumed;
    int            stale;
    logic [DW-1:0] pc_nxt;
    rv = 1'b0;
    if (inflight.size() > 0) begin
      if (inflight[0].wait_cyc == 0) rv = 1'b1;
      else inflight[0].wait_cyc = inflight[0].wait_cyc - 1;
    end
    mem_rvalid = rv;
    mem_rdata  = rv ? word_of(inflight[0].pc) : '0;
    @(negedge clk);
    s_req   = mem_req;
    s_pcen  = pc_en;
    s_valid = inst_valid;
    head_live = rv && inflight[0].live;
    stale = 0;
    for (int i = 0; i < inflight.size(); i++) if (!inflight[i].live) stale++;
    exp_req = clr && !flush && (stale == 0) && (exp_q.size() < int'(DEPTH));
    check1("mem_req", mem_req, exp_req);
    check1("pc_en", pc_en, exp_req & mem_gnt);
    check32("mem_addr", mem_addr, pc_in);
    byp = Byp && head_live && !flush && (exp_q.size() > 0) && !exp_q[0].arrived;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].arrived || byp);
    check1("inst_valid", inst_valid, exp_valid);
    consumed = 1'b0;
    if (exp_valid && inst_ready && !flush) begin
      check32("inst_pc", inst_pc, exp_q[0].pc);
      check32("inst_data", inst_data, word_of(exp_q[0].pc));
      if (want_first) begin
        first_pc   = inst_pc;
        want_first = 1'b0;
      end
      consumed = byp;
      void'(exp_q.pop_front());
    end
    if (rv) begin
      if (head_live && !flush && !consumed) begin
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && !exp_q[i].arrived) idx = i;
        if (idx >= 0) exp_q[idx].arrived = 1'b1;
        else check1("orphan_rsp", 1'b1, 1'b0);
      end
      void'(inflight.pop_front());
    end
    if (flush) begin
      for (int i = 0; i < inflight.size(); i++) inflight[i].live = 1'b0;
      exp_q.delete();
    end
    if (mem_req && mem_gnt) begin
      inflight.push_back('{pc: mem_addr,
                           wait_cyc: rand_wait ? $urandom_range(0, 3) : next_wait,
                           live: 1'b1});
      exp_q.push_back('{pc: pc_in, arrived: 1'b0});
    end
    pc_nxt = pc_in;
    if (flush) pc_nxt = flush_pc;
    else if (pc_en) pc_nxt = pc_in + 32'd4;
    @(posedge clk);
    #1;
    pc_in = pc_nxt;
  endtask

  task automatic do_reset();
    clr        = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    flush      = 1'b0;
    mem_gnt    = 1'b0;
    inst_ready = 1'b0;
    pc_in      = '0;
    inflight.delete();
    exp_q.delete();
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_pc_en", pc_en, 1'b0);
    check1("rst_inst_valid", inst_valid, 1'b0);
    check32("rst_inst_data", inst_data, '0);
    check32("rst_inst_pc", inst_pc, '0);
    @(negedge clk);
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  task automatic drain();
    inst_ready = 1'b1;
    mem_gnt    = 1'b0;
    for (int i = 0; i < 40 && (inflight.size() > 0 || exp_q.size() > 0); i++) step();
    check1("drain_done", (inflight.size() == 0 && exp_q.size() == 0), 1'b1);
  endtask

  vec_t vecs[10];

  initial begin
    // Latency 1, grant always; stall decode for 6 cycles then release.
    vecs[0] = '{gnt: 1'b1, ready: 1'b0, exp_req: 1'b1, exp_valid: 1'b0};
    vecs[1] = '{gnt: 1'b1, ready: 1'b0, exp_req: 1'b1, exp_valid: Byp};
    vecs[2] = '{gnt: 1'b1, ready: 1'b0, exp_req: 1'b1, exp_valid: 1'b1};
    vecs[3] = '{gnt: 1'b1, ready: 1'b0, exp_req: 1'b1, exp_valid: 1'b1};
    vecs[4] = '{gnt: 1'b1, ready: 1'b0, exp_req: 1'b0, exp_valid: 1'b1};
    vecs[5] = '{gnt: 1'b1, ready: 1'b0, exp_req: 1'b0, exp_valid: 1'b1};
    vecs[6] = '{gnt: 1'b1, ready: 1'b1, exp_req: 1'b0, exp_valid: 1'b1};
    vecs[7] = '{gnt: 1'b1, ready: 1'b1, exp_req: 1'b1, exp_valid: 1'b1};
    vecs[8] = '{gnt: 1'b1, ready: 1'b1, exp_req: 1'b1, exp_valid: 1'b1};
    vecs[9] = '{gnt: 1'b1, ready: 1'b1, exp_req: 1'b1, exp_valid: 1'b1};

    do_reset();
    rand_wait = 1'b0;
    next_wait = 0;
    for (int i = 0; i < 10; i++) begin
      mem_gnt    = vecs[i].gnt;
      inst_ready = vecs[i].ready;
      step();
      check1($sformatf("vec%0d_req", i), s_req, vecs[i].exp_req);
      check1($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
    end
    drain();

    // Flush with one buffered entry and two requests in flight.
    inst_ready = 1'b0;
    mem_gnt    = 1'b1;
    next_wait  = 0;
    step();
    next_wait = 4;
    step();
    step();
    mem_gnt  = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h100;
    step();
    check1("flush_cycle_req", s_req, 1'b0);
    check1("flush_cycle_pc_en", s_pcen, 1'b0);
    flush      = 1'b0;
    mem_gnt    = 1'b1;
    inst_ready = 1'b1;
    next_wait  = 0;
    step();
    check1("post_flush_valid", s_valid, 1'b0);
    check1("discard_req", s_req, 1'b0);
    want_first = 1'b1;
    first_pc   = 32'hdead_dead;
    for (int i = 0; i < 40 && want_first; i++) step();
    check32("first_pc_after_flush", first_pc, 32'h100);
    drain();

    // Flush coinciding with the only outstanding response.
    next_wait = 0;
    mem_gnt   = 1'b1;
    step();
    mem_gnt  = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h200;
    step();
    flush   = 1'b0;
    mem_gnt = 1'b1;
    step();
    check1("req_after_flush_rsp", s_req, 1'b1);
    check1("dropped_rsp_valid", s_valid, 1'b0);
    drain();

    // Bypass visibility: a lone response with an empty FIFO and decode ready.
    next_wait = 0;
    mem_gnt   = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    check1("rsp_cycle_valid", s_valid, Byp);
    step();
    check1("rsp_next_valid", s_valid, !Byp);
    drain();

    // Reset mid-stream with three requests outstanding.
    inst_ready = 1'b0;
    mem_gnt    = 1'b1;
    next_wait  = 5;
    step();
    step();
    step();
    mem_gnt = 1'b0;
    #2;
    do_reset();
    mem_gnt    = 1'b1;
    inst_ready = 1'b1;
    next_wait  = 0;
    want_first = 1'b1;
    first_pc   = 32'hdead_dead;
    for (int i = 0; i < 20 && want_first; i++) step();
    check32("first_pc_after_reset", first_pc, 32'h0);

    // Random traffic.
    rand_wait = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      mem_gnt    = ($urandom_range(0, 9) < 7);
      inst_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 31) == 0);
      flush_pc   = $urandom() & 32'hffff_fffc;
      step();
    end
    flush = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
